// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, defaults and PC helpers for the fetch pipeline
package pipe_pkg;

    localparam int INST_W = 32;
    localparam int IMM_W  = 16;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h0000_0000;

    // Fetch addresses are always word aligned; the low two bits of any
    // incoming target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with redirect/stall/advance priority
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   redirect_valid   load redirect_target (word aligned); beats stall
//   redirect_target  new PC, bits [1:0] ignored
//   stall            hold PC
//   advance          instruction accepted this cycle, step PC by 4
//   pc               current fetch PC
//   pc_plus4         pc + 4, modulo 2^32
module pc_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 gives 0.
    assign pc_plus4 = pc + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_target);
        end else if (stall) begin
            pc <= pc;
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage plus IF/ID pipeline register
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         fetch address (equals pc)
//   imem_rdata        instruction word for imem_addr, valid when imem_ready
//   imem_ready        imem_rdata valid this cycle
//   stall             hold PC and IF/ID
//   flush             squash IF/ID
//   redirect_valid    taken branch/jump from EX
//   redirect_target   new PC, bits [1:0] ignored
//   id_inst           IF/ID instruction
//   id_imm            id_inst[15:0]
//   id_pc_plus4       IF/ID PC+4
//   id_valid          IF/ID holds a real instruction
//
// Build option IF_ID_DELAY_SLOT_EN: when defined, a redirect does not squash
// IF/ID, so the delay-slot word fetched alongside the redirect proceeds.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0]       RESET_PC = DEFAULT_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic [INST_W-1:0] id_inst,
    output logic [IMM_W-1:0]  id_imm,
    output logic [31:0]       id_pc_plus4,
    output logic              id_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        squash;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .advance         (imem_ready),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    assign imem_addr = pc;

`ifdef IF_ID_DELAY_SLOT_EN
    assign squash = flush;
`else
    assign squash = flush | redirect_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst     <= NOP_INST;
            id_pc_plus4 <= 32'h0000_0000;
            id_valid    <= 1'b0;
        end else if (squash) begin
            // id_pc_plus4 is left alone; it is meaningless while id_valid=0.
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (stall) begin
            id_inst     <= id_inst;
            id_pc_plus4 <= id_pc_plus4;
            id_valid    <= id_valid;
        end else if (imem_ready) begin
            id_inst     <= imem_rdata;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end else begin
            // Memory wait: insert a bubble.
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end
    end

    assign id_imm = id_inst[IMM_W-1:0];

endmodule
